wb_dbg_master: RTL and testbench

- Wishbone initiator driven by a byte-stream command interface.
- Lets a host (through a UART byte stream) read and write any slave on the interconnect, including bram0, uart0 and timer0.
- Sits on a spare interconnect master port (m2) next to the LM32 instruction and data masters.
- Converts framed command bytes into single 32-bit Wishbone classic cycles and returns framed status/data bytes.

---
 rtl/wb_dbg_master.sv | 203 ++++++++++++++++++++
 tb/tb_wb_dbg_master.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dbg_master.sv
// Byte-stream command front end issuing single 32-bit Wishbone classic cycles.
// Optional macro WB_DBG_AUTOINC_EN adds write-next/read-next with address auto-increment.
module wb_dbg_master #(
  parameter int unsigned timeout_cycles = 1024,
  parameter logic [7:0]  cmd_write      = 8'h01,
  parameter logic [7:0]  cmd_read       = 8'h02
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  output logic        busy
);
  localparam logic [7:0]  ST_ACK    = 8'h00;
  localparam logic [7:0]  ST_ERR    = 8'h01;
  localparam logic [7:0]  ST_RTY    = 8'h02;
  localparam logic [7:0]  ST_TMO    = 8'h03;
  localparam logic [7:0]  ST_BADOP  = 8'h04;
  localparam logic [15:0] TMO_LIMIT = 16'(timeout_cycles);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] rdat_q, rdat_d;
  logic [7:0]  status_q, status_d;
  logic [15:0] tmo_q, tmo_d;
  logic        cyc_q, cyc_d;
  logic        txv_q, txv_d;
  logic [7:0]  txd_q, txd_d;
  logic [2:0]  idx_q, idx_d;
  logic        rx_acc, tx_acc, bus_done;
  logic [2:0]  last_idx;

  assign rx_ready = !reset && (state_q == IDLE || state_q == ADDR || state_q == DATA);
  assign rx_acc   = rx_valid && rx_ready;
  assign tx_acc   = txv_q && tx_ready;
  // Only a successful read carries the four data bytes after the status byte.
  assign last_idx = (status_q == ST_ACK && !we_q) ? 3'd4 : 3'd0;

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    rdat_d   = rdat_q;
    status_d = status_q;
    tmo_d    = tmo_q;
    cyc_d    = cyc_q;
    txv_d    = txv_q;
    txd_d    = txd_q;
    idx_d    = idx_q;
    bus_done = 1'b0;
    unique case (state_q)
      IDLE: if (rx_acc) begin
        cnt_d = 2'd0;
        if (rx_data == cmd_write) begin
          we_d    = 1'b1;
          state_d = ADDR;
        end else if (rx_data == cmd_read) begin
          we_d    = 1'b0;
          state_d = ADDR;
`ifdef WB_DBG_AUTOINC_EN
        end else if (rx_data == 8'h03) begin
          we_d    = 1'b1;
          state_d = DATA;
        end else if (rx_data == 8'h04) begin
          we_d    = 1'b0;
          state_d = BUS;
          cyc_d   = 1'b1;
          tmo_d   = 16'd0;
`endif
        end else begin
          status_d = ST_BADOP;
          state_d  = RESP;
          txv_d    = 1'b1;
          txd_d    = ST_BADOP;
          idx_d    = 3'd0;
        end
      end
      ADDR: if (rx_acc) begin
        adr_d = {adr_q[23:0], rx_data};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          if (we_q) begin
            state_d = DATA;
          end else begin
            state_d = BUS;
            cyc_d   = 1'b1;
            tmo_d   = 16'd0;
          end
        end
      end
      DATA: if (rx_acc) begin
        wdat_d = {wdat_q[23:0], rx_data};
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          tmo_d   = 16'd0;
        end
      end
      BUS: begin
        bus_done = 1'b1;
        if (wb_err_i) begin
          status_d = ST_ERR;
        end else if (wb_rty_i) begin
          status_d = ST_RTY;
        end else if (wb_ack_i) begin
          status_d = ST_ACK;
          if (!we_q) rdat_d = wb_dat_i;
`ifdef WB_DBG_AUTOINC_EN
          adr_d = adr_q + 32'd4;
`endif
        end else begin
          tmo_d = tmo_q + 16'd1;
          if (tmo_d == TMO_LIMIT) status_d = ST_TMO;
          else bus_done = 1'b0;
        end
        if (bus_done) begin
          cyc_d   = 1'b0;
          state_d = RESP;
          txv_d   = 1'b1;
          txd_d   = status_d;
          idx_d   = 3'd0;
        end
      end
      RESP: if (tx_acc) begin
        if (idx_q == last_idx) begin
          txv_d   = 1'b0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 3'd1;
          case (idx_q)
            3'd0:    txd_d = rdat_q[31:24];
            3'd1:    txd_d = rdat_q[23:16];
            3'd2:    txd_d = rdat_q[15:8];
            default: txd_d = rdat_q[7:0];
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      cnt_q    <= 2'd0;
      adr_q    <= 32'd0;
      wdat_q   <= 32'd0;
      rdat_q   <= 32'd0;
      status_q <= 8'd0;
      tmo_q    <= 16'd0;
      cyc_q    <= 1'b0;
      txv_q    <= 1'b0;
      txd_q    <= 8'd0;
      idx_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
      status_q <= status_d;
      tmo_q    <= tmo_d;
      cyc_q    <= cyc_d;
      txv_q    <= txv_d;
      txd_q    <= txd_d;
      idx_q    <= idx_d;
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_sel_o = {4{cyc_q}};
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = wdat_q;
  assign tx_valid = txv_q;
  assign tx_data  = txd_q;
  assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_wb_dbg_master.sv
// Directed, table-driven bench for wb_dbg_master with a scripted Wishbone slave and host.
module tb_wb_dbg_master;
  localparam int T_NONE = 0, T_ACK = 1, T_ERR = 2, T_RTY = 3, T_ACKERR = 4;
  localparam int NV = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic        wb_ack_i, wb_err_i, wb_rty_i;
  logic        busy;

  always #5 clk = ~clk;

  wb_dbg_master #(.timeout_cycles(16)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i), .busy(busy)
  );

  typedef struct {
    logic [7:0]  op;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    int          n_in;
    int          term;
    int          dly;
    int          exp_cyc;
    int          exp_ntx;
    logic [39:0] exp_tx;
    int          stall_idx;
    int          stall_len;
  } vec_t;

  vec_t tbl [NV];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] op, input logic [31:0] adr,
                              input logic [31:0] wdat, input logic [31:0] rdat,
                              input int term, input int dly, input int exp_cyc,
                              input int exp_ntx, input logic [39:0] exp_tx,
                              input int stall_idx, input int stall_len);
    vec_t v;
    v.op = op; v.adr = adr; v.wdat = wdat; v.rdat = rdat;
    v.term = term; v.dly = dly; v.exp_cyc = exp_cyc; v.exp_ntx = exp_ntx;
    v.exp_tx = exp_tx; v.stall_idx = stall_idx; v.stall_len = stall_len;
    if (op == 8'h01) v.n_in = 9;
    else if (op == 8'h02) v.n_in = 5;
    else v.n_in = 1;
    return v;
  endfunction

  // Called just after a falling edge; returns on the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL rx_accept: rx_ready stayed %0b expected 1", rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0]  b;
    logic [31:0] cap_adr, cap_dat;
    logic        cap_we;
    logic [3:0]  cap_sel;
    logic        bus_stable, tx_stable;
    logic [39:0] got_tx;
    logic [7:0]  held;
    int          ncyc, ntx, stall_left, guard;
    for (int i = 0; i < v.n_in; i++) begin
      if (i == 0) b = v.op;
      else if (i < 5) b = v.adr[8*(4-i) +: 8];
      else b = v.wdat[8*(8-i) +: 8];
      send_byte(b);
    end
    ncyc = 0; bus_stable = 1'b1;
    cap_adr = '0; cap_dat = '0; cap_we = 1'b0; cap_sel = '0;
    for (int c = 0; c < 60; c++) begin
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      wb_dat_i = 32'hBAD0_BAD0;
      if (wb_cyc_o) begin
        if (ncyc == 0) begin
          cap_adr = wb_adr_o; cap_dat = wb_dat_o; cap_we = wb_we_o; cap_sel = wb_sel_o;
          if (wb_stb_o !== 1'b1) bus_stable = 1'b0;
        end else if (wb_adr_o !== cap_adr || wb_dat_o !== cap_dat ||
                     wb_we_o !== cap_we || wb_stb_o !== 1'b1 || wb_sel_o !== cap_sel) begin
          bus_stable = 1'b0;
        end
        ncyc++;
        if (ncyc == v.dly + 1) begin
          case (v.term)
            T_ACK:    begin wb_ack_i = 1'b1; wb_dat_i = v.rdat; end
            T_ERR:    wb_err_i = 1'b1;
            T_RTY:    wb_rty_i = 1'b1;
            T_ACKERR: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = v.rdat; end
            default:  ;
          endcase
        end
      end else if (ncyc > 0 || tx_valid) begin
        break;
      end
      @(negedge clk);
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    chk({tag, " cyc_len"}, ncyc, v.exp_cyc);
    if (v.exp_cyc > 0) begin
      chk({tag, " adr"}, cap_adr, v.adr);
      chk({tag, " we"}, cap_we, (v.op == 8'h01 || v.op == 8'h03));
      chk({tag, " sel"}, cap_sel, 4'hF);
      chk({tag, " bus_stable"}, bus_stable, 1'b1);
      if (v.op == 8'h01) chk({tag, " wdat"}, cap_dat, v.wdat);
    end

    ntx = 0; got_tx = '0; stall_left = v.stall_len; guard = 0;
    tx_stable = 1'b1; held = 8'h00;
    while (guard < 100) begin
      if (tx_valid) begin
        if (ntx == v.stall_idx && stall_left > 0) begin
          if (stall_left == v.stall_len) held = tx_data;
          else if (tx_data !== held) tx_stable = 1'b0;
          tx_ready = 1'b0;
          stall_left--;
        end else begin
          if (v.stall_len > 0 && ntx == v.stall_idx && tx_data !== held) tx_stable = 1'b0;
          tx_ready = 1'b1;
          if (ntx < 5) got_tx[8*(4-ntx) +: 8] = tx_data;
          ntx++;
        end
      end else begin
        tx_ready = 1'b0;
        if (ntx > 0) break;
      end
      @(negedge clk);
      guard++;
    end
    tx_ready = 1'b0;
    chk({tag, " tx_count"}, ntx, v.exp_ntx);
    chk({tag, " tx_bytes"}, got_tx, v.exp_tx);
    if (v.stall_len > 0) chk({tag, " tx_hold"}, tx_stable, 1'b1);
    chk({tag, " idle_after"}, {busy, rx_ready}, 2'b01);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;

    tbl[0] = mk(8'h01, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, T_ACK, 3, 4, 1, 40'h00_0000_0000, 0, 0);
    tbl[1] = mk(8'h02, 32'hF000_0004, 32'h0, 32'h1234_5678, T_ACK, 1, 2, 5, 40'h00_1234_5678, 2, 5);
    tbl[2] = mk(8'h02, 32'hDEAD_0000, 32'h0, 32'h0, T_NONE, 0, 16, 1, 40'h03_0000_0000, 0, 0);
    tbl[3] = mk(8'h01, 32'h0000_0020, 32'h0000_0001, 32'h0, T_ACKERR, 0, 1, 1, 40'h01_0000_0000, 0, 0);
    tbl[4] = mk(8'h02, 32'h0000_0030, 32'h0, 32'h0, T_RTY, 2, 3, 1, 40'h02_0000_0000, 0, 0);
    tbl[5] = mk(8'h7F, 32'h0, 32'h0, 32'h0, T_NONE, 0, 0, 1, 40'h04_0000_0000, 0, 0);
    tbl[6] = mk(8'h02, 32'h0000_0000, 32'h0, 32'hA5A5_5A5A, T_ACK, 0, 1, 5, 40'h00_A5A5_5A5A, 0, 2);
    tbl[7] = mk(8'h02, 32'h0000_0044, 32'h0, 32'hFFFF_FFFF, T_ERR, 4, 5, 1, 40'h01_0000_0000, 0, 0);
`ifdef WB_DBG_AUTOINC_EN
    tbl[8] = mk(8'h01, 32'hFFFF_FFFC, 32'hCAFE_F00D, 32'h0, T_ACK, 0, 1, 1, 40'h00_0000_0000, 0, 0);
    tbl[9] = mk(8'h04, 32'h0000_0000, 32'h0, 32'h1122_3344, T_ACK, 1, 2, 5, 40'h00_1122_3344, 0, 0);
`else
    tbl[8] = mk(8'h03, 32'h0, 32'h0, 32'h0, T_NONE, 0, 0, 1, 40'h04_0000_0000, 0, 0);
    tbl[9] = mk(8'h04, 32'h0, 32'h0, 32'h0, T_NONE, 0, 0, 1, 40'h04_0000_0000, 0, 0);
`endif

    repeat (3) @(negedge clk);
    chk("rst_ctrl", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, tx_valid, busy, rx_ready}, 10'd0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_txd", tx_data, 8'h00);
    reset = 1'b0;
    @(negedge clk);
    chk("rx_ready_idle", rx_ready, 1'b1);

    for (int i = 0; i < NV; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Abort a read two cycles into its bus phase, then run a clean write.
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
    chk("midbus_cyc_up", wb_cyc_o, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midbus_rst", {wb_cyc_o, wb_stb_o, tx_valid, busy}, 4'b0000);
    reset = 1'b0;
    @(negedge clk);
    run_vec(mk(8'h01, 32'h0000_0050, 32'h1357_9BDF, 32'h0, T_ACK, 2, 3, 1, 40'h00_0000_0000, 0, 0),
            "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
